// File: rtl/uart_cmd_framer.sv
// uart_cmd_framer: CRLF-terminated command framer between the byte-level uart
// core and user logic. Good frames are published atomically on info/frame_len
// with a one-cycle update strobe. Each frame is answered with ACK_BYTE or
// NAK_BYTE through a small TX byte queue.
// Optional build macro UART_CMD_ECHO_EN: echo every received byte through the
// TX queue, with the frame reply placed after the echoed LF.
module uart_cmd_framer #(
    parameter int unsigned NBYTES    = 4,
    parameter int unsigned TXQ_DEPTH = 4,
    parameter logic [7:0]  ACK_BYTE  = 8'h4B,
    parameter logic [7:0]  NAK_BYTE  = 8'h45
) (
    input  logic                          sys_clk,
    input  logic                          rst,
    input  logic                          rx_valid,
    input  logic [7:0]                    rx_byte,
    input  logic                          rx_error,
    input  logic                          tx_busy,
    output logic                          tx_start,
    output logic [7:0]                    tx_byte,
    output logic [8*NBYTES-1:0]           info,
    output logic [$clog2(NBYTES+1)-1:0]   frame_len,
    output logic                          update,
    output logic                          overflow_err,
    output logic                          tx_overrun
);
    localparam int unsigned CW  = $clog2(NBYTES + 1);
    localparam int unsigned AW  = $clog2(TXQ_DEPTH);
    localparam int unsigned QCW = AW + 1;
    localparam int unsigned FW  = QCW + 1;
    localparam logic [7:0]  CR  = 8'h0D;
    localparam logic [7:0]  LF  = 8'h0A;

    typedef enum logic [1:0] {COLLECT, GOT_CR, DISCARD} state_t;

    state_t              state_q;
    logic [8*NBYTES-1:0] wbuf_q;
    logic [CW-1:0]       cnt_q;
    logic                disc_cr_q;
    logic [8*NBYTES-1:0] info_q;
    logic [CW-1:0]       frame_len_q;
    logic                update_q;
    logic                overflow_err_q;

    logic                is_cr;
    logic                is_lf;
    logic                room1;
    logic                room2;
    logic                reject;
    logic                reply_now;
    logic [7:0]          reply_byte;

    // Decode the incoming strobe: frame rejection and frame-end reply
    always_comb begin
        is_cr      = (rx_byte == CR);
        is_lf      = (rx_byte == LF);
        room1      = (32'(cnt_q) < NBYTES);
        room2      = (32'(cnt_q) + 32'd1 < NBYTES);
        reject     = rx_error;
        reply_now  = 1'b0;
        reply_byte = ACK_BYTE;
        if (!rx_error && rx_valid) begin
            unique case (state_q)
                COLLECT: reject = !is_cr && !room1;
                GOT_CR: begin
                    if (is_lf)      reply_now = 1'b1;
                    else if (is_cr) reject = !room1;
                    else            reject = !room2;
                end
                DISCARD: begin
                    if (is_lf && disc_cr_q) begin
                        reply_now  = 1'b1;
                        reply_byte = NAK_BYTE;
                    end
                end
                default: ;
            endcase
        end
    end

    // Frame assembly FSM: collect payload, track CR, publish good frames
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_q        <= COLLECT;
            wbuf_q         <= '0;
            cnt_q          <= '0;
            disc_cr_q      <= 1'b0;
            info_q         <= '0;
            frame_len_q    <= '0;
            update_q       <= 1'b0;
            overflow_err_q <= 1'b0;
        end else begin
            update_q       <= 1'b0;
            overflow_err_q <= 1'b0;
            if (reject) begin
                // A CR that overflowed the buffer still counts toward the CRLF
                // that closes the discarded frame.
                state_q        <= DISCARD;
                wbuf_q         <= '0;
                cnt_q          <= '0;
                disc_cr_q      <= rx_valid && !rx_error && is_cr;
                overflow_err_q <= 1'b1;
            end else if (rx_valid) begin
                unique case (state_q)
                    COLLECT: begin
                        if (is_cr) begin
                            state_q <= GOT_CR;
                        end else begin
                            for (int unsigned k = 0; k < NBYTES; k++) begin
                                if (k == 32'(cnt_q)) wbuf_q[8*k +: 8] <= rx_byte;
                            end
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                    GOT_CR: begin
                        if (is_lf) begin
                            info_q      <= wbuf_q;
                            frame_len_q <= cnt_q;
                            update_q    <= 1'b1;
                            wbuf_q      <= '0;
                            cnt_q       <= '0;
                            state_q     <= COLLECT;
                        end else if (is_cr) begin
                            for (int unsigned k = 0; k < NBYTES; k++) begin
                                if (k == 32'(cnt_q)) wbuf_q[8*k +: 8] <= CR;
                            end
                            cnt_q <= cnt_q + CW'(1);
                        end else begin
                            for (int unsigned k = 0; k < NBYTES; k++) begin
                                if (k == 32'(cnt_q))         wbuf_q[8*k +: 8] <= CR;
                                if (k == 32'(cnt_q) + 32'd1) wbuf_q[8*k +: 8] <= rx_byte;
                            end
                            cnt_q   <= cnt_q + CW'(2);
                            state_q <= COLLECT;
                        end
                    end
                    DISCARD: begin
                        if (is_lf && disc_cr_q) begin
                            state_q   <= COLLECT;
                            disc_cr_q <= 1'b0;
                        end else begin
                            disc_cr_q <= is_cr;
                        end
                    end
                    default: state_q <= COLLECT;
                endcase
            end
        end
    end

    logic [7:0]     qmem_q [TXQ_DEPTH];
    logic [AW-1:0]  wr_q;
    logic [AW-1:0]  rd_q;
    logic [QCW-1:0] qcnt_q;
    logic           tx_start_q;
    logic [7:0]     tx_byte_q;
    logic           tx_overrun_q;

    logic           push_a;
    logic           push_b;
    logic [7:0]     data_a;
    logic [7:0]     data_b;
    logic           pop;
    logic           acc_a;
    logic           acc_b;
    logic [FW-1:0]  free;

`ifdef UART_CMD_ECHO_EN
    logic       reply_pend_q;
    logic [7:0] reply_pend_byte_q;

    // Hold the reply one cycle so it lands behind the echo of its LF
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            reply_pend_q      <= 1'b0;
            reply_pend_byte_q <= '0;
        end else begin
            reply_pend_q      <= reply_now;
            reply_pend_byte_q <= reply_byte;
        end
    end

    // Push sources: delayed reply first, then the echo of the current byte
    always_comb begin
        push_a = reply_pend_q;
        data_a = reply_pend_byte_q;
        push_b = rx_valid;
        data_b = rx_byte;
    end
`else
    // Push source: the reply alone, in the cycle the frame closes
    always_comb begin
        push_a = reply_now;
        data_a = reply_byte;
        push_b = 1'b0;
        data_b = '0;
    end
`endif

    // Queue arbitration: a pop in the same cycle frees a slot for a push
    always_comb begin
        pop   = (qcnt_q != '0) && !tx_busy && !tx_start_q;
        free  = FW'(TXQ_DEPTH) - FW'(qcnt_q) + FW'(pop);
        acc_a = push_a && (free != '0);
        acc_b = push_b && (free > FW'(acc_a));
    end

    // Queue pointers, transmit issue with one guard cycle, sticky overrun
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            wr_q         <= '0;
            rd_q         <= '0;
            qcnt_q       <= '0;
            tx_start_q   <= 1'b0;
            tx_byte_q    <= '0;
            tx_overrun_q <= 1'b0;
        end else begin
            tx_start_q <= pop;
            if (pop) begin
                tx_byte_q <= qmem_q[rd_q];
                rd_q      <= rd_q + AW'(1);
            end
            wr_q   <= wr_q + AW'(acc_a) + AW'(acc_b);
            qcnt_q <= qcnt_q + QCW'(acc_a) + QCW'(acc_b) - QCW'(pop);
            if ((push_a && !acc_a) || (push_b && !acc_b)) tx_overrun_q <= 1'b1;
        end
    end

    // Queue storage; the reply slot is written ahead of a same-cycle echo
    always_ff @(posedge sys_clk) begin
        if (acc_a) qmem_q[wr_q] <= data_a;
        if (acc_b) qmem_q[wr_q + AW'(acc_a)] <= data_b;
    end

    assign tx_start     = tx_start_q;
    assign tx_byte      = tx_byte_q;
    assign info         = info_q;
    assign frame_len    = frame_len_q;
    assign update       = update_q;
    assign overflow_err = overflow_err_q;
    assign tx_overrun   = tx_overrun_q;

endmodule

// File: tb/tb_uart_cmd_framer.sv
// tb_uart_cmd_framer: directed frames with hand-computed results; a monitor
// pops expected info/frame_len, overflow pulses and TX bytes from queues.
`timescale 1ns/1ps
module tb_uart_cmd_framer;
    localparam int unsigned NB  = 4;
    localparam int unsigned QD  = 4;
    localparam logic [7:0]  ACK = 8'h4B;
    localparam logic [7:0]  NAK = 8'h45;
    localparam logic [7:0]  CR  = 8'h0D;
    localparam logic [7:0]  LF  = 8'h0A;
    localparam int          GAP = 5;

    logic        sys_clk   = 1'b0;
    logic        rst       = 1'b1;
    logic        rx_valid  = 1'b0;
    logic [7:0]  rx_byte   = 8'h00;
    logic        rx_error  = 1'b0;
    logic        hold_busy = 1'b0;
    logic        tx_busy;
    logic        tx_start;
    logic [7:0]  tx_byte;
    logic [31:0] info;
    logic [2:0]  frame_len;
    logic        update;
    logic        overflow_err;
    logic        tx_overrun;

    int          busy_cnt  = 0;
    logic        prev_busy = 1'b0;
    int          n_checks  = 0;
    int          n_err     = 0;
    logic [31:0] exp_info [$];
    logic [2:0]  exp_len  [$];
    logic [7:0]  exp_tx   [$];
    int          exp_ovf   = 0;
    logic        exp_overrun = 1'b0;

    assign tx_busy = hold_busy | (busy_cnt != 0);

    always #5 sys_clk = ~sys_clk;

    uart_cmd_framer #(
        .NBYTES   (NB),
        .TXQ_DEPTH(QD),
        .ACK_BYTE (ACK),
        .NAK_BYTE (NAK)
    ) dut (
        .sys_clk     (sys_clk),
        .rst         (rst),
        .rx_valid    (rx_valid),
        .rx_byte     (rx_byte),
        .rx_error    (rx_error),
        .tx_busy     (tx_busy),
        .tx_start    (tx_start),
        .tx_byte     (tx_byte),
        .info        (info),
        .frame_len   (frame_len),
        .update      (update),
        .overflow_err(overflow_err),
        .tx_overrun  (tx_overrun)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // Monitor: scoreboard compare on the falling edge, plus a small uart busy model
    initial begin
        forever begin
            @(negedge sys_clk);
            if (update) begin
                if (exp_info.size() == 0) begin
                    n_checks++; n_err++;
                    $display("FAIL update_unexpected: got update=1 info=%h, required no update", info);
                end else begin
                    check("info", info, exp_info.pop_front());
                    check("frame_len", frame_len, exp_len.pop_front());
                end
            end
            if (overflow_err) begin
                n_checks++;
                if (exp_ovf == 0) begin
                    n_err++;
                    $display("FAIL overflow_err_unexpected: got pulse, required none");
                end else begin
                    exp_ovf--;
                end
            end
            if (busy_cnt > 0) busy_cnt--;
            if (tx_start) begin
                check("tx_start_guard_busy", prev_busy, 1'b0);
                if (exp_tx.size() == 0) begin
                    n_checks++; n_err++;
                    $display("FAIL tx_unexpected: got tx_byte=%h, required no tx_start", tx_byte);
                end else begin
                    check("tx_byte", tx_byte, exp_tx.pop_front());
                end
                busy_cnt = 3;
            end
            prev_busy = hold_busy | (busy_cnt != 0);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic push_tx(input logic [7:0] b);
        if (hold_busy && exp_tx.size() >= QD) exp_overrun = 1'b1;
        else exp_tx.push_back(b);
    endtask

    task automatic push_info(input logic [31:0] i, input logic [2:0] l);
        exp_info.push_back(i);
        exp_len.push_back(l);
    endtask

    task automatic sb(input logic [7:0] b);
`ifdef UART_CMD_ECHO_EN
        push_tx(b);
`endif
        rx_valid = 1'b1; rx_byte = b;
        cyc();
        rx_valid = 1'b0;
        repeat (GAP) cyc();
    endtask

    task automatic sb_last(input logic [7:0] b, input bit good, input logic [7:0] reply);
`ifdef UART_CMD_ECHO_EN
        push_tx(b);
`endif
        push_tx(reply);
        rx_valid = 1'b1; rx_byte = b;
        cyc();
        rx_valid = 1'b0;
        if (good) check("update_latency", update, 1'b1);
        repeat (GAP) cyc();
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) sb(8'(s[i]));
    endtask

    task automatic wait_drain();
        int t = 0;
        while ((exp_tx.size() != 0 || exp_info.size() != 0 || exp_ovf != 0 || tx_busy) && t < 1000) begin
            cyc();
            t++;
        end
        if (t >= 1000) begin
            n_checks++; n_err++;
            $display("FAIL drain_timeout: tx left %0d, info left %0d, ovf left %0d",
                     exp_tx.size(), exp_info.size(), exp_ovf);
        end
        repeat (3) cyc();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_info"}, info, 32'h0);
        check({tag, "_frame_len"}, frame_len, 3'd0);
        check({tag, "_update"}, update, 1'b0);
        check({tag, "_overflow_err"}, overflow_err, 1'b0);
        check({tag, "_tx_start"}, tx_start, 1'b0);
        check({tag, "_tx_byte"}, tx_byte, 8'h00);
        check({tag, "_tx_overrun"}, tx_overrun, 1'b0);
    endtask

    initial begin
        repeat (3) cyc();
        check_all_zero("reset");
        rst = 1'b0;
        cyc();

        // Full frame at capacity
        push_info(32'h44434241, 3'd4);
        send_str("ABCD"); sb(CR); sb_last(LF, 1'b1, ACK);
        wait_drain();

        // Short frame, unfilled bytes zero
        push_info(32'h00004241, 3'd2);
        send_str("AB"); sb(CR); sb_last(LF, 1'b1, ACK);
        wait_drain();

        // Oversize: NAK, info holds
        exp_ovf++;
        send_str("ABCDE"); sb(CR); sb_last(LF, 1'b0, NAK);
        wait_drain();
        check("info_hold_after_nak", info, 32'h00004241);
        check("len_hold_after_nak", frame_len, 3'd2);

        // Empty frame
        push_info(32'h00000000, 3'd0);
        sb(CR); sb_last(LF, 1'b1, ACK);
        wait_drain();

        // Embedded CR followed by data
        push_info(32'h00420D41, 3'd3);
        send_str("A"); sb(CR); send_str("B"); sb(CR); sb_last(LF, 1'b1, ACK);
        wait_drain();

        // CR CR LF keeps one CR as data
        push_info(32'h00000D41, 3'd2);
        send_str("A"); sb(CR); sb(CR); sb_last(LF, 1'b1, ACK);
        wait_drain();

        // CR+byte pair does not fit in the last slot
        exp_ovf++;
        send_str("ABC"); sb(CR); send_str("D"); sb(CR); sb_last(LF, 1'b0, NAK);
        wait_drain();

        // rx_error alone mid-frame
        exp_ovf++;
        send_str("A");
        rx_error = 1'b1; cyc(); rx_error = 1'b0; repeat (GAP) cyc();
        sb(CR); sb_last(LF, 1'b0, NAK);
        wait_drain();

        // rx_error together with rx_valid: error wins
        exp_ovf++;
        send_str("A");
`ifdef UART_CMD_ECHO_EN
        push_tx(8'h42);
`endif
        rx_error = 1'b1; rx_valid = 1'b1; rx_byte = 8'h42;
        cyc();
        rx_error = 1'b0; rx_valid = 1'b0; repeat (GAP) cyc();
        sb(CR); sb_last(LF, 1'b0, NAK);
        wait_drain();
        check("info_hold_after_err", info, 32'h00000D41);

        // Single byte frame (echo build: 5A,0D,0A,4B)
        push_info(32'h0000005A, 3'd1);
        send_str("Z"); sb(CR); sb_last(LF, 1'b1, ACK);
        wait_drain();
        check("tx_overrun_clear", tx_overrun, 1'b0);

        // Queue overrun with the core held busy
        hold_busy = 1'b1;
        for (int i = 0; i < 6; i++) begin
            push_info(32'h0, 3'd0);
            sb(CR); sb_last(LF, 1'b1, ACK);
        end
        repeat (4) cyc();
        check("tx_overrun_set", tx_overrun, exp_overrun);
        check("queued_count", exp_tx.size(), QD);
        hold_busy = 1'b0;
        wait_drain();
        check("tx_overrun_sticky", tx_overrun, 1'b1);

        // Reset mid-frame
        send_str("AB");
        wait_drain();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        exp_overrun = 1'b0;
        check_all_zero("midrst");
        cyc();
        check("midrst_update_next", update, 1'b0);
        check("midrst_tx_start_next", tx_start, 1'b0);
        push_info(32'h00000043, 3'd1);
        send_str("C"); sb(CR); sb_last(LF, 1'b1, ACK);
        wait_drain();

        check("exp_tx_left", exp_tx.size(), 0);
        check("exp_info_left", exp_info.size(), 0);
        check("exp_ovf_left", exp_ovf, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
